// File: rtl/cache_access_ctrl.sv
// Round-robin front end for the shared word cache and backing RAM: lookup, dirty writeback, refill, replay.
// Hit: req sampled -> ack 3 cycles later; requesters hold req until ack, extra requests wait in place.
module cache_access_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255,
  parameter int CW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          c_en,
  output logic [AW-1:0] c_addr,
  output logic          c_rw,
  output logic [DW-1:0] c_wdata,
  input  logic          c_hit,
  input  logic          c_dirty,
  input  logic [AW-1:0] c_victim_addr,
  input  logic [DW-1:0] c_rdata,
  output logic          c_fill,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  input  logic          m_ack,
  output logic          err,
  output logic [CW-1:0] hit_cnt,
  output logic [CW-1:0] miss_cnt
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, WB, REFILL, FILL, RESP} state_t;

  state_t        state, state_n;
  logic          sel_d;
  logic          last_d;
  logic          blk_i, blk_d;
  logic [AW-1:0] addr_q;
  logic          rw_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] victim_q;
  logic          replay;
  logic [TW-1:0] tcnt;

  logic          grant_v, grant_d, conflict;
  logic          req_i, req_d;
  logic          resp_ld, set_err;
  logic [DW-1:0] resp_val;
  logic          tmo;

  assign req_i = i_req & ~blk_i;
  assign req_d = d_req & ~blk_d;
  assign tmo   = (tcnt == TW'(TIMEOUT)) & ~m_ack;

  always_comb begin
    state_n  = state;
    grant_v  = 1'b0;
    grant_d  = 1'b0;
    conflict = 1'b0;
    resp_ld  = 1'b0;
    resp_val = c_rdata;
    set_err  = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          grant_v  = 1'b1;
          grant_d  = ~last_d;
          conflict = 1'b1;
        end else if (req_i || req_d) begin
          grant_v = 1'b1;
          grant_d = req_d;
        end
        if (grant_v) state_n = LOOKUP;
      end
      LOOKUP: state_n = CHECK;
      CHECK: begin
        if (c_hit) begin
          resp_ld = 1'b1;
          state_n = RESP;
        end else if (replay) begin
          // refilled line still misses: give up on this access
          resp_ld  = 1'b1;
          resp_val = '0;
          set_err  = 1'b1;
          state_n  = RESP;
        end else if (c_dirty) begin
          state_n = WB;
        end else begin
          state_n = REFILL;
        end
      end
      WB, REFILL: begin
        if (m_ack) begin
          state_n = (state == WB) ? REFILL : FILL;
        end else if (tmo) begin
          resp_ld  = 1'b1;
          resp_val = '0;
          set_err  = 1'b1;
          state_n  = RESP;
        end
      end
      FILL:    state_n = LOOKUP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sel_d    <= 1'b0;
      last_d   <= 1'b1;
      blk_i    <= 1'b0;
      blk_d    <= 1'b0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wdata_q  <= '0;
      victim_q <= '0;
      replay   <= 1'b0;
      tcnt     <= '0;
      err      <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_n;
      // just-acked requester still shows req for one cycle; keep it out of arbitration
      blk_i <= (state == RESP) & ~sel_d;
      blk_d <= (state == RESP) & sel_d;
      tcnt  <= (state_n != state) ? '0 : tcnt + TW'(1);
      if (grant_v) begin
        sel_d   <= grant_d;
        addr_q  <= grant_d ? d_addr : i_addr;
        rw_q    <= grant_d & d_rw;
        wdata_q <= grant_d ? d_wdata : '0;
        replay  <= 1'b0;
        if (conflict) last_d <= grant_d;
      end
      if (state == CHECK) begin
        victim_q <= c_victim_addr;
        if (!replay) begin
          if (c_hit) hit_cnt  <= hit_cnt + CW'(1);
          else       miss_cnt <= miss_cnt + CW'(1);
        end
      end
      if (state == FILL) replay <= 1'b1;
      if (set_err) err <= 1'b1;
      if (resp_ld) begin
        if (sel_d) d_rdata <= resp_val;
        else       i_rdata <= resp_val;
      end
    end
  end

  always_comb begin
    c_en    = (state == LOOKUP);
    c_addr  = addr_q;
    c_rw    = (state == LOOKUP) & rw_q;
    c_wdata = wdata_q;
    c_fill  = (state == FILL);
    m_req   = (state == WB) || (state == REFILL);
    m_we    = (state == WB);
    m_addr  = '0;
    if (state == WB)     m_addr = {victim_q[AW-1:4], 4'b0000};
    if (state == REFILL) m_addr = {addr_q[AW-1:4], 4'b0000};
    i_ack   = (state == RESP) & ~sel_d;
    d_ack   = (state == RESP) & sel_d;
  end

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Directed bench for cache_access_ctrl: the bench plays cache and memory and checks hand-computed values.
module tb_cache_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        c_en;
  logic [31:0] c_addr;
  logic        c_rw;
  logic [31:0] c_wdata;
  logic        c_hit;
  logic        c_dirty;
  logic [31:0] c_victim_addr;
  logic [31:0] c_rdata;
  logic        c_fill;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic        m_ack;
  logic        err;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks   = 0;
  int failures = 0;

  cache_access_ctrl dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .c_en(c_en), .c_addr(c_addr), .c_rw(c_rw), .c_wdata(c_wdata),
    .c_hit(c_hit), .c_dirty(c_dirty), .c_victim_addr(c_victim_addr), .c_rdata(c_rdata),
    .c_fill(c_fill),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_ack(m_ack),
    .err(err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_addr = 0;
    d_req = 0; d_rw = 0; d_addr = 0; d_wdata = 0;
    c_hit = 1; c_dirty = 0; c_victim_addr = 0; c_rdata = 32'hDEADBEEF;
    m_ack = 0;
    do_reset();

    // reset state
    chk("rst_c_en", c_en, 0);
    chk("rst_m_req", m_req, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    chk("rst_err", err, 0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 0);

    // read hit at 0x40
    d_req = 1; d_rw = 0; d_addr = 32'h40;
    tick();
    chk("hit_c_en_cyc1", c_en, 1);
    chk("hit_c_addr", c_addr, 32'h40);
    chk("hit_c_rw", c_rw, 0);
    tick();
    chk("hit_no_ack_cyc2", d_ack, 0);
    tick();
    chk("hit_d_ack_cyc3", d_ack, 1);
    chk("hit_d_rdata", d_rdata, 32'hDEADBEEF);
    chk("hit_cnt1", hit_cnt, 1);
    d_req = 0;
    tick();
    chk("hit_ack_pulse", d_ack, 0);
    tick();

    // simultaneous: instruction wins first conflict
    i_req = 1; i_addr = 32'h100; d_req = 1; d_addr = 32'h200;
    tick();
    chk("rr1_first_i", c_addr, 32'h100);
    tick(); tick();
    chk("rr1_i_ack", {i_ack, d_ack}, 2'b10);
    chk("rr1_i_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 0;
    tick();
    tick();
    chk("rr1_then_d", c_addr, 32'h200);
    tick(); tick();
    chk("rr1_d_ack", {i_ack, d_ack}, 2'b01);
    d_req = 0;
    tick(); tick();
    // next conflict goes to data
    i_req = 1; i_addr = 32'h104; d_req = 1; d_addr = 32'h204;
    tick();
    chk("rr2_first_d", c_addr, 32'h204);
    tick(); tick();
    chk("rr2_d_ack", {i_ack, d_ack}, 2'b01);
    d_req = 0;
    tick(); tick();
    chk("rr2_then_i", c_addr, 32'h104);
    tick(); tick();
    chk("rr2_i_ack", {i_ack, d_ack}, 2'b10);
    i_req = 0;
    tick(); tick();
    chk("rr_hit_cnt", hit_cnt, 5);

    // clean read miss at 0x1234
    do_reset();
    d_req = 1; d_rw = 0; d_addr = 32'h1234;
    tick();
    c_hit = 0; c_dirty = 0;
    tick();
    tick();
    chk("rm_m_req", {m_req, m_we}, 2'b10);
    chk("rm_m_addr", m_addr, 32'h1230);
    chk("rm_miss_cnt", miss_cnt, 1);
    repeat (4) tick();
    chk("rm_m_req_held", m_req, 1);
    m_ack = 1;
    tick();
    m_ack = 0;
    chk("rm_c_fill", {c_fill, m_req}, 2'b10);
    c_hit = 1; c_rdata = 32'hCAFE0001;
    tick();
    chk("rm_replay_c_en", {c_en, c_fill}, 2'b10);
    tick(); tick();
    chk("rm_d_ack", d_ack, 1);
    chk("rm_d_rdata", d_rdata, 32'hCAFE0001);
    chk("rm_cnts", {hit_cnt, miss_cnt}, {32'd0, 32'd1});
    d_req = 0;
    tick(); tick();

    // dirty write miss with writeback
    d_req = 1; d_rw = 1; d_addr = 32'h2004; d_wdata = 32'h12345678;
    tick();
    chk("wm_c_rw_first", c_rw, 1);
    c_hit = 0; c_dirty = 1; c_victim_addr = 32'h8008;
    tick();
    tick();
    chk("wm_wb", {m_req, m_we}, 2'b11);
    chk("wm_wb_addr", m_addr, 32'h8000);
    m_ack = 1;
    tick();
    m_ack = 0;
    chk("wm_refill", {m_req, m_we}, 2'b10);
    chk("wm_refill_addr", m_addr, 32'h2000);
    m_ack = 1;
    tick();
    m_ack = 0;
    chk("wm_fill", c_fill, 1);
    c_hit = 1; c_dirty = 0;
    tick();
    chk("wm_replay", {c_en, c_rw}, 2'b11);
    chk("wm_replay_wdata", c_wdata, 32'h12345678);
    tick(); tick();
    chk("wm_d_ack", {d_ack, err}, 2'b10);
    chk("wm_cnts", {hit_cnt, miss_cnt}, {32'd0, 32'd2});
    d_req = 0; d_rw = 0;
    tick(); tick();

    // refill timeout
    d_req = 1; d_addr = 32'h3000;
    tick();
    c_hit = 0;
    tick(); tick();
    repeat (255) tick();
    chk("to_last_wait", {m_req, err}, 2'b10);
    tick();
    chk("to_err", {m_req, err, d_ack}, 3'b011);
    chk("to_d_rdata", d_rdata, 0);
    d_req = 0;
    tick(); tick();
    chk("to_err_sticky", err, 1);

    // async reset mid-refill
    d_req = 1; d_addr = 32'h5000;
    tick(); tick(); tick();
    chk("ar_in_refill", m_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_m_req_drop", m_req, 0);
    chk("ar_err_cnts", {err, hit_cnt, miss_cnt}, 0);
    d_req = 0;
    #1 rst = 1'b0;
    tick();
    c_hit = 1; c_rdata = 32'hA5A5A5A5;
    d_req = 1; d_addr = 32'h60;
    tick();
    chk("ar_new_lookup", {c_en, c_addr}, {1'b1, 32'h60});
    tick(); tick();
    chk("ar_new_ack", d_ack, 1);
    chk("ar_new_rdata", d_rdata, 32'hA5A5A5A5);
    chk("ar_hit_cnt", hit_cnt, 1);
    d_req = 0;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_access_ctrl.md
Name: cache_access_ctrl

Overview:
- Sequences the shared 16-way-indexed word cache and its backing RAM on behalf of two requesters: instruction fetch (read-only) and data load/store.
- Arbitrates round-robin between them and runs cache lookup.
- On a miss, writes back the dirty victim line, refills from memory, then replays the lookup.
- Sits between the RISC-V core front end / LSU and the cache + RAM datapath. Keeps hit/miss counters for performance analysis.

Parameters:
- AW, 32, address width
- DW, 32, data word width
- TIMEOUT, 255, max cycles to wait for m_ack before flagging error
- CW, 32, width of hit/miss counters

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction read request, held until i_ack
- i_addr  in  AW  instruction address
- i_ack  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DW  fetched word
- d_req  in  1  data request, held until d_ack
- d_rw  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid on reads
- d_rdata  out  DW  load data
- c_en  out  1  cache lookup strobe
- c_addr  out  AW  cache address (index = c_addr[5:2])
- c_rw  out  1  cache write enable on hit
- c_wdata  out  DW  cache write data
- c_hit  in  1  lookup hit, valid cycle after c_en
- c_dirty  in  1  victim dirty, valid cycle after c_en
- c_victim_addr  in  AW  victim line address, valid with c_dirty
- c_rdata  in  DW  cache read data, valid with c_hit
- c_fill  out  1  one-cycle pulse: install refill line from memory
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  1 = writeback, 0 = refill
- m_addr  out  AW  memory line address
- m_ack  in  1  memory completion pulse
- err  out  1  sticky memory timeout flag
- hit_cnt  out  CW  lookups that hit (first lookup only)
- miss_cnt  out  CW  lookups that missed

Behaviour:
- Reset (async, any state):
  - state=IDLE; all outputs 0; counters 0; err=0; last_grant=D (instruction wins first conflict).
  - Any in-flight m_req is dropped.
- States: IDLE, LOOKUP, CHECK, WB, REFILL, FILL, RESP.
- IDLE:
  - If i_req or d_req: pick winner; latch addr, rw (forced 0 for instruction), wdata; go LOOKUP.
  - If both requests are present, grant the port not granted last; update last_grant.
- LOOKUP: c_en=1 for exactly one cycle; c_addr/c_rw/c_wdata = latched values. Go to CHECK.
- CHECK: sample c_hit, c_dirty, c_victim_addr, c_rdata.
  - hit: latch c_rdata; go RESP.
  - miss, dirty: go WB.
  - miss, clean: go REFILL.
  - hit_cnt/miss_cnt increment only on the first CHECK of a transaction; the replay is not counted.
- WB: m_req=1, m_we=1, m_addr = c_victim_addr with [3:0] cleared. On m_ack go REFILL.
- REFILL: m_req=1, m_we=0, m_addr = latched addr with [3:0] cleared. On m_ack go FILL.
- FILL: c_fill=1 for one cycle, then LOOKUP (replay).
  - If the replay misses again: set err, respond with rdata=0.
- RESP: pulse winner's ack for one cycle; rdata driven that cycle and held until next ack. Then IDLE.
- The same requester cannot be re-granted in the cycle after its ack; it must drop req.
- Hit latency: req sampled at cycle 0 → ack at cycle 3.
- Miss latency: 3 + WB/REFILL memory cycles + 3.
- Writes on hit: cache updates word during the LOOKUP cycle. Write miss: refill, then the replay writes.
- Timeout:
  - Counter resets on entry to WB/REFILL and counts while waiting for m_ack.
  - At TIMEOUT: set err (sticky until rst), drop m_req, go RESP with rdata=0.
- Counters wrap modulo 2^CW.
- Requests arriving while busy wait; no request is ever dropped.

Test Plan:
- Reset, then d_req read 0x40 that hits (c_hit=1, c_rdata=0xDEADBEEF) → c_en at cycle 1, d_ack at cycle 3, d_rdata=0xDEADBEEF, hit_cnt=1.
- i_req and d_req both asserted at cycle 0 after reset → instruction served first, data granted in the IDLE after i_ack; the next simultaneous pair goes to data first.
- Clean read miss at 0x1234 → m_req=1, m_we=0, m_addr=0x1230; m_ack after 5 cycles → c_fill pulse, replay lookup hits, d_ack; miss_cnt=1, hit_cnt=0.
- Dirty write miss, c_victim_addr=0x8008 → WB with m_addr=0x8000, m_we=1, then REFILL, FILL, replay with c_rw=1 and c_wdata=d_wdata, then d_ack.
- m_ack withheld for TIMEOUT+1 cycles → err=1, m_req drops, d_ack with d_rdata=0; err stays 1 until rst.
- rst asserted mid-REFILL → m_req=0 immediately (async), counters 0, state IDLE; a new request afterwards completes normally.
